// File: rtl/csr_access_unit_if.sv
// Purpose: bundles the issue handshake, CSR read values and CSR-file/fetch drive of csr_access_unit.
// Latency: wiring only, no logic.
// Backpressure: instr_valid/instr_ready transfer; the slave holds instr_ready low while busy.
// Ports: master = issuing EX stage plus CSR-file read side; slave = csr_access_unit.
interface csr_access_unit_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [1:0]      instr_kind;
    logic [2:0]      funct3;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] rs1_data;
    logic [4:0]      zimm;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] mepc_rd;
    logic [XLEN-1:0] mcause_rd;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] mtvec_rd;
    logic [XLEN-1:0] mvendorid_rd;
    logic [XLEN-1:0] marchid_rd;
    logic [XLEN-1:0] csrd;
    logic [3:0]      csr_wen;
    logic            ecall_flag;
    logic [XLEN-1:0] pc;
    logic            rd_valid;
    logic [XLEN-1:0] rd_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            illegal;

    modport master (
        output instr_valid, instr_kind, funct3, csr_addr, rs1_data, zimm, instr_pc,
               mepc_rd, mcause_rd, mstatus_rd, mtvec_rd, mvendorid_rd, marchid_rd,
        input  instr_ready, csrd, csr_wen, ecall_flag, pc, rd_valid, rd_data,
               redirect_valid, redirect_pc, flush, illegal
    );

    modport slave (
        input  instr_valid, instr_kind, funct3, csr_addr, rs1_data, zimm, instr_pc,
               mepc_rd, mcause_rd, mstatus_rd, mtvec_rd, mvendorid_rd, marchid_rd,
        output instr_ready, csrd, csr_wen, ecall_flag, pc, rd_valid, rd_data,
               redirect_valid, redirect_pc, flush, illegal
    );
endinterface

// File: rtl/csr_access_unit.sv
// Purpose: EX-stage CSR read/modify/write, ECALL and MRET sequencer in front of the machine-mode CSR file.
// Latency: CSR op result 1 cycle after transfer; ECALL redirect at +2, MRET redirect at +1; flush then FLUSH_CYCLES more.
// Backpressure: instr_ready is high only in IDLE; one instruction in flight at a time.
// Ports: clock, reset (async, active-high); bus = csr_access_unit_if.slave (issue handshake, CSR read values,
//        csrd/csr_wen/ecall_flag/pc toward the CSR file, rd writeback, redirect/flush toward fetch).
// Option: define ILLEGAL_CSR_TRAP_EN to turn illegal CSR accesses into a trap (mcause = 2) to mtvec.
module csr_access_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic               clock,
    input  logic               reset,
    csr_access_unit_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, WB, TRAP, REDIR, DRAIN} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_funct3;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_rs1;
    logic [4:0]      r_zimm;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_target;
    logic [3:0]      r_cnt;
    logic            r_ill_trap;   // current TRAP was entered from an illegal CSR access

    logic            w_xfer;
    logic [XLEN-1:0] w_old, w_src, w_new;
    logic [3:0]      w_wsel;
    logic            w_mapped_ro, w_wr_intent, w_illegal;

    assign w_xfer = bus.instr_valid && bus.instr_ready;

    // Read mux and write-target decode for the captured address.
    always_comb begin
        w_old       = '0;
        w_wsel      = 4'b0000;
        w_mapped_ro = 1'b0;
        case (r_addr)
            12'h341: begin w_old = bus.mepc_rd;    w_wsel = 4'b0001; end
            12'h342: begin w_old = bus.mcause_rd;  w_wsel = 4'b0010; end
            12'h300: begin w_old = bus.mstatus_rd; w_wsel = 4'b0100; end
            12'h305: begin w_old = bus.mtvec_rd;   w_wsel = 4'b1000; end
            12'hF11: begin w_old = bus.mvendorid_rd; w_mapped_ro = 1'b1; end
            12'hF12: begin w_old = bus.marchid_rd;   w_mapped_ro = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_src = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_zimm} : r_rs1;
        case (r_funct3[1:0])
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_src;
        endcase
        // Set/clear with a zero zimm/rs1 index is a pure read, so it is legal on read-only CSRs.
        w_wr_intent = (r_funct3[1:0] == 2'b01) || (r_zimm != 5'd0);
        w_illegal   = (r_funct3[1:0] == 2'b00) || (w_wr_intent && (w_wsel == 4'b0000));
    end

    // Next state and Moore-style outputs; every output idles at 0.
    always_comb begin
        w_next             = r_state;
        bus.csrd           = '0;
        bus.csr_wen        = 4'b0000;
        bus.ecall_flag     = 1'b0;
        bus.pc             = '0;
        bus.rd_valid       = 1'b0;
        bus.rd_data        = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.flush          = 1'b0;
        bus.illegal        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    case (bus.instr_kind)
                        2'd0:    w_next = WB;
                        2'd1:    w_next = TRAP;
                        2'd2:    w_next = REDIR;
                        default: w_next = IDLE;
                    endcase
                end
            end
            WB: begin
                w_next = IDLE;
                if (w_illegal) begin
                    bus.illegal = 1'b1;
`ifdef ILLEGAL_CSR_TRAP_EN
                    w_next = TRAP;
`endif
                end else begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = w_old;
                    bus.csrd     = w_new;
                    bus.csr_wen  = w_wr_intent ? w_wsel : 4'b0000;
                end
            end
            TRAP: begin
                w_next         = REDIR;
                bus.ecall_flag = 1'b1;
                bus.pc         = r_pc;
                if (r_ill_trap) begin
                    // Overrides the CSR file's default mcause=11 with illegal-instruction.
                    bus.csrd    = XLEN'(2);
                    bus.csr_wen = 4'b0010;
                end
            end
            REDIR: begin
                w_next             = DRAIN;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = {r_target[XLEN-1:2], 2'b00};
                bus.flush          = 1'b1;
            end
            DRAIN: begin
                bus.flush = 1'b1;
                if (r_cnt == 4'd0) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.instr_ready = (r_state == IDLE) && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_funct3   <= '0;
            r_addr     <= '0;
            r_rs1      <= '0;
            r_zimm     <= '0;
            r_pc       <= '0;
            r_target   <= '0;
            r_cnt      <= '0;
            r_ill_trap <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_funct3 <= bus.funct3;
                r_addr   <= bus.csr_addr;
                r_rs1    <= bus.rs1_data;
                r_zimm   <= bus.zimm;
                r_pc     <= bus.instr_pc;
                if (bus.instr_kind == 2'd2) r_target <= bus.mepc_rd;
            end
            if (r_state == TRAP) begin
                r_target   <= bus.mtvec_rd;
                r_ill_trap <= 1'b0;
            end
`ifdef ILLEGAL_CSR_TRAP_EN
            if (r_state == WB && w_illegal) r_ill_trap <= 1'b1;
`endif
            // Counter holds the remaining DRAIN cycles minus one.
            if (r_state == REDIR)                    r_cnt <= 4'(FLUSH_CYCLES - 1);
            else if (r_state == DRAIN && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    csr_access_unit_if #(.XLEN(32)) bus ();

    csr_access_unit #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction at a negedge, then move to the negedge of cycle T+1 with valid dropped.
    task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] rs1, input logic [4:0] zimm, input logic [31:0] ipc);
        bus.instr_valid = 1'b1;
        bus.instr_kind  = kind;
        bus.funct3      = f3;
        bus.csr_addr    = addr;
        bus.rs1_data    = rs1;
        bus.zimm        = zimm;
        bus.instr_pc    = ipc;
        @(negedge clock);
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        bus.instr_valid  = 1'b0;
        bus.instr_kind   = '0;
        bus.funct3       = '0;
        bus.csr_addr     = '0;
        bus.rs1_data     = '0;
        bus.zimm         = '0;
        bus.instr_pc     = '0;
        bus.mepc_rd      = 32'h0;
        bus.mcause_rd    = 32'h10;
        bus.mstatus_rd   = 32'h1800;
        bus.mtvec_rd     = 32'h0;
        bus.mvendorid_rd = 32'hABCD_0001;
        bus.marchid_rd   = 32'h0000_0055;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_wen", {28'd0, bus.csr_wen}, 32'd0);
        reset = 1'b0;
        #1 chk("post_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        @(negedge clock);

        // CSRRW mtvec
        issue(2'd0, 3'd1, 12'h305, 32'h8000_0100, 5'd0, 32'h0);
        chk("rw_wen", {28'd0, bus.csr_wen}, 32'h8);
        chk("rw_csrd", bus.csrd, 32'h8000_0100);
        chk("rw_rdv", {31'd0, bus.rd_valid}, 32'd1);
        chk("rw_rdd", bus.rd_data, 32'h0);
        chk("rw_busy", {31'd0, bus.instr_ready}, 32'd0);
        @(negedge clock);
        chk("rw_ready_back", {31'd0, bus.instr_ready}, 32'd1);
        chk("rw_rdv_off", {31'd0, bus.rd_valid}, 32'd0);

        // CSRRS mstatus with zimm=0: read only
        issue(2'd0, 3'd2, 12'h300, 32'h0, 5'd0, 32'h0);
        chk("rs0_rdd", bus.rd_data, 32'h1800);
        chk("rs0_wen", {28'd0, bus.csr_wen}, 32'h0);
        chk("rs0_ill", {31'd0, bus.illegal}, 32'd0);
        @(negedge clock);

        // CSRRCI mstatus zimm=8
        issue(2'd0, 3'd7, 12'h300, 32'hFFFF_FFFF, 5'd8, 32'h0);
        chk("rci_csrd", bus.csrd, 32'h1800);
        chk("rci_wen", {28'd0, bus.csr_wen}, 32'h4);
        @(negedge clock);

        // CSRRSI mcause zimm=3: 0x10 | 3
        issue(2'd0, 3'd6, 12'h342, 32'h0, 5'd3, 32'h0);
        chk("rsi_csrd", bus.csrd, 32'h13);
        chk("rsi_wen", {28'd0, bus.csr_wen}, 32'h2);
        chk("rsi_rdd", bus.rd_data, 32'h10);
        @(negedge clock);

        // CSRRC mepc from rs1: 0xFF & ~0x0F
        bus.mepc_rd = 32'hFF;
        issue(2'd0, 3'd3, 12'h341, 32'h0F, 5'd1, 32'h0);
        chk("rc_csrd", bus.csrd, 32'hF0);
        chk("rc_wen", {28'd0, bus.csr_wen}, 32'h1);
        @(negedge clock);

        // CSRRS marchid with rs1=x0: legal read of read-only CSR
        issue(2'd0, 3'd2, 12'hF12, 32'h0, 5'd0, 32'h0);
        chk("ro_rd_rdd", bus.rd_data, 32'h55);
        chk("ro_rd_rdv", {31'd0, bus.rd_valid}, 32'd1);
        chk("ro_rd_ill", {31'd0, bus.illegal}, 32'd0);
        @(negedge clock);

        // Unmapped read returns 0
        issue(2'd0, 3'd2, 12'h123, 32'h0, 5'd0, 32'h0);
        chk("unm_rdd", bus.rd_data, 32'h0);
        chk("unm_rdv", {31'd0, bus.rd_valid}, 32'd1);
        @(negedge clock);

        // ECALL at pc 0x40, mtvec 0x200
        bus.mtvec_rd = 32'h200;
        issue(2'd1, 3'd0, 12'h0, 32'h0, 5'd0, 32'h40);
        chk("ec_flag", {31'd0, bus.ecall_flag}, 32'd1);
        chk("ec_pc", bus.pc, 32'h40);
        chk("ec_wen", {28'd0, bus.csr_wen}, 32'h0);
        chk("ec_flush_t1", {31'd0, bus.flush}, 32'd0);
        @(negedge clock);
        chk("ec_rv", {31'd0, bus.redirect_valid}, 32'd1);
        chk("ec_rpc", bus.redirect_pc, 32'h200);
        chk("ec_flush_t2", {31'd0, bus.flush}, 32'd1);
        chk("ec_flag_off", {31'd0, bus.ecall_flag}, 32'd0);
        @(negedge clock);
        chk("ec_flush_t3", {31'd0, bus.flush}, 32'd1);
        chk("ec_rv_t3", {31'd0, bus.redirect_valid}, 32'd0);
        @(negedge clock);
        chk("ec_flush_t4", {31'd0, bus.flush}, 32'd1);
        chk("ec_busy_t4", {31'd0, bus.instr_ready}, 32'd0);
        @(negedge clock);
        chk("ec_flush_t5", {31'd0, bus.flush}, 32'd0);
        chk("ec_ready_t5", {31'd0, bus.instr_ready}, 32'd1);

        // MRET to mepc 0x46 (low bits cleared)
        bus.mepc_rd = 32'h46;
        issue(2'd2, 3'd0, 12'h0, 32'h0, 5'd0, 32'h0);
        chk("mr_rv", {31'd0, bus.redirect_valid}, 32'd1);
        chk("mr_rpc", bus.redirect_pc, 32'h44);
        chk("mr_wen", {28'd0, bus.csr_wen}, 32'h0);
        chk("mr_flush", {31'd0, bus.flush}, 32'd1);
        repeat (2) @(negedge clock);
        chk("mr_busy_t3", {31'd0, bus.instr_ready}, 32'd0);
        @(negedge clock);
        chk("mr_ready_t4", {31'd0, bus.instr_ready}, 32'd1);
        chk("mr_flush_t4", {31'd0, bus.flush}, 32'd0);

        // CSRRW to read-only mvendorid: illegal
        issue(2'd0, 3'd1, 12'hF11, 32'h1234, 5'd0, 32'h0);
        chk("ill_ro", {31'd0, bus.illegal}, 32'd1);
        chk("ill_ro_wen", {28'd0, bus.csr_wen}, 32'h0);
        chk("ill_ro_rdv", {31'd0, bus.rd_valid}, 32'd0);
        chk("ill_ro_ecall", {31'd0, bus.ecall_flag}, 32'd0);
        @(negedge clock);
        chk("ill_ro_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("ill_ro_pulse", {31'd0, bus.illegal}, 32'd0);

        // funct3 = 4 is illegal even on a writable CSR
        issue(2'd0, 3'd4, 12'h305, 32'h1, 5'd1, 32'h0);
        chk("ill_f3", {31'd0, bus.illegal}, 32'd1);
        chk("ill_f3_wen", {28'd0, bus.csr_wen}, 32'h0);
        @(negedge clock);

        // Reserved kind: consumed without effect
        issue(2'd3, 3'd1, 12'h305, 32'h1, 5'd0, 32'h0);
        chk("rsv_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("rsv_wen", {28'd0, bus.csr_wen}, 32'h0);
        chk("rsv_rv", {31'd0, bus.redirect_valid}, 32'd0);

        // Reset during DRAIN
        issue(2'd2, 3'd0, 12'h0, 32'h0, 5'd0, 32'h0);
        @(negedge clock);
        chk("drain_flush", {31'd0, bus.flush}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.instr_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("rst_rel_ready", {31'd0, bus.instr_ready}, 32'd1);
        @(negedge clock);
        chk("rst_rel_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_rel_rv", {31'd0, bus.redirect_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- EX-stage front end for the machine-mode CSR register file; sits directly upstream of it.
- Accepts one decoded SYSTEM instruction at a time: CSR read/modify/write, ECALL or MRET.
- Produces the `csrd`, `csr_wen`, `ecall_flag` and `pc` drive for the CSR file, the rd writeback value, and the PC redirect/flush toward fetch.
- Multi-cycle FSM; stalls the issuing stage via a valid/ready handshake.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush` stays asserted after the redirect cycle (1..15).
- XLEN, 32, data/PC width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  EX stage presents an instruction
- instr_ready  out  1  unit can accept; transfer = instr_valid & instr_ready
- instr_kind  in  2  0 = CSR op, 1 = ECALL, 2 = MRET, 3 = reserved
- funct3  in  3  CSR op: 1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI
- csr_addr  in  12  CSR address
- rs1_data  in  32  register source operand
- zimm  in  5  immediate / rs1 index
- instr_pc  in  32  PC of the instruction
- mepc_rd, mcause_rd, mstatus_rd, mtvec_rd, mvendorid_rd, marchid_rd  in  32 each  current CSR values
- csrd  out  32  write data to the CSR file
- csr_wen  out  4  one-hot write enable: [0] mepc, [1] mcause, [2] mstatus, [3] mtvec
- ecall_flag  out  1  trap capture strobe to the CSR file
- pc  out  32  trap PC to the CSR file
- rd_valid  out  1  rd_data is valid this cycle
- rd_data  out  32  old CSR value for rd
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  32  redirect target
- flush  out  1  squash younger instructions
- illegal  out  1  one-cycle illegal CSR access pulse

Behaviour:
- Reset (async, active-high): state IDLE; every output 0 except `instr_ready`, which is 0 during reset and 1 from the first cycle after deassertion. Reset mid-sequence aborts it; no partial writes are issued afterwards.
- Address map:
  - 0x341 mepc, 0x342 mcause, 0x300 mstatus, 0x305 mtvec are read/write.
  - 0xF11 mvendorid and 0xF12 marchid are read-only.
  - Any other address is unmapped.
- States: IDLE, WB, TRAP, REDIR, DRAIN. `instr_ready` = 1 only in IDLE.
- IDLE, on transfer: capture all inputs into registers, then dispatch on `instr_kind`:
  - 0 (CSR op) -> WB.
  - 1 (ECALL) -> TRAP.
  - 2 (MRET) -> REDIR with target = mepc_rd.
  - 3 (reserved) -> consumed as a no-op; stay in IDLE.
- WB (exactly 1 cycle, then IDLE):
  - old = the read-mux value for the captured address; unmapped reads return 0.
  - src = rs1_data for funct3[2] = 0, otherwise zero-extended zimm.
  - new = src (RW/RWI), old | src (RS/RSI), old & ~src (RC/RCI).
  - Drive `rd_valid` = 1, `rd_data` = old, `csrd` = new.
  - `csr_wen` bit for the mapped writable address is set unless the op is RS/RC/RSI/RCI with zimm = 0. The zimm field equals the rs1 index, so this rule also suppresses writes for RS/RC with rs1 = x0.
  - A write to a read-only or unmapped address, or funct3 ∈ {0, 4}: `csr_wen` = 0, `illegal` = 1, `rd_valid` = 0.
- TRAP (1 cycle): `ecall_flag` = 1, `pc` = captured instr_pc, `csr_wen` = 0. The CSR file loads mepc = pc and mcause = 11. -> REDIR with target = mtvec_rd sampled in this cycle.
- REDIR (1 cycle): `redirect_valid` = 1, `redirect_pc` = {target[31:2], 2'b00}, `flush` = 1. -> DRAIN.
- DRAIN: `flush` = 1 for FLUSH_CYCLES cycles via a down-counter; at 0 -> IDLE. `redirect_valid` = 0.
- Priority and ordering:
  - No new transfer is possible outside IDLE, so CSR writes and trap capture can never coincide.
  - The CSR file sees writes before the next instruction can read them, so back-to-back CSR ops see updated values.
- Latencies from transfer:
  - CSR op: result in the next cycle; 2 cycles before `instr_ready` returns.
  - ECALL: redirect 2 cycles after transfer; `instr_ready` returns after 3 + FLUSH_CYCLES cycles.
  - MRET: redirect 1 cycle after transfer; `instr_ready` returns after 2 + FLUSH_CYCLES cycles.

Optional Feature:
- Macro ILLEGAL_CSR_TRAP_EN.
- Defined: an illegal access in WB still pulses `illegal`, then goes to TRAP instead of IDLE, with `ecall_flag` = 1.
  - Unit drives `csrd` = 2 with csr_wen[1] = 1 in the same cycle, overriding mcause to illegal-instruction.
  - Target is mtvec, as for ECALL.
- Undefined: an illegal access only pulses `illegal` and returns to IDLE; no trap.

Test Plan:
- Reset released; CSRRW 0x305, rs1_data = 0x8000_0100, mtvec_rd = 0 -> next cycle csr_wen = 4'b1000, csrd = 0x8000_0100, rd_valid = 1, rd_data = 0.
- mstatus_rd = 0x1800; CSRRS 0x300, zimm = 0 -> rd_data = 0x1800, csr_wen = 0. Then CSRRCI zimm = 8 -> csrd = 0x1800, csr_wen = 4'b0100.
- ECALL at instr_pc = 0x40, mtvec_rd = 0x200 (FLUSH_CYCLES = 2) -> T+1 ecall_flag = 1 with pc = 0x40; T+2 redirect 0x200; flush high T+2..T+4; instr_ready high at T+5.
- MRET with mepc_rd = 0x44 -> redirect_valid at T+1 with redirect_pc = 0x44; no csr_wen; ready at T+4.
- CSRRW to 0xF11 -> illegal = 1, csr_wen = 0. With ILLEGAL_CSR_TRAP_EN: also mcause write of 2 plus ecall_flag, then redirect to mtvec.
- Assert reset during DRAIN -> all outputs 0 immediately; after release, IDLE with instr_ready = 1 and no residual flush.
